// File: rtl/btn_cond_multi.sv
// btn_cond_multi: N-channel pushbutton conditioner.
// Each channel has a 2-flop synchroniser, a debouncer and a hold-state machine
// that emits single-cycle press/release/short-tap/long-press pulses.
// Optional auto-repeat while a long press is held: define BTN_REPEAT_EN.
module btn_cond_multi #(
    parameter int N_CH         = 4,
    parameter int DEBOUNCE_CYC = 50000,
    parameter int LONG_CYC     = 250000000,
    parameter int ACTIVE_LOW   = 0,
    parameter int REPEAT_CYC   = 25000000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_lvl,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] short_pulse,
    output logic [N_CH-1:0] long_pulse,
    output logic [N_CH-1:0] long_lvl,
    output logic [N_CH-1:0] rep_pulse
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam int HOLD_W = $clog2(LONG_CYC + 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYC);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [N_CH-1:0]   POL_MASK  = (ACTIVE_LOW != 0) ? '1 : '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HELD,
        ST_LONG
    } hold_state_e;

    logic [N_CH-1:0]   sync1_q, sync2_q;
    logic [N_CH-1:0]   btn_lvl_q, btn_lvl_d;
    logic [N_CH-1:0]   press_q, press_d;
    logic [N_CH-1:0]   release_q, release_d;
    logic [N_CH-1:0]   short_q, short_d;
    logic [N_CH-1:0]   long_q, long_d;
    logic [N_CH-1:0]   long_lvl_q, long_lvl_d;
    logic [N_CH-1:0]   rise, fall;
    logic [DB_W-1:0]   db_cnt_q [N_CH];
    logic [DB_W-1:0]   db_cnt_d [N_CH];
    logic [HOLD_W-1:0] hold_cnt_q [N_CH];
    logic [HOLD_W-1:0] hold_cnt_d [N_CH];
    hold_state_e       state_q [N_CH];
    hold_state_e       state_d [N_CH];

    // Normalise polarity so 1 always means pressed, then resynchronise; reset loads "released".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_in ^ POL_MASK;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: a level change is accepted only after DEBOUNCE_CYC consecutive differing samples.
    always_comb begin
        btn_lvl_d = btn_lvl_q;
        rise      = '0;
        fall      = '0;
        for (int i = 0; i < N_CH; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != btn_lvl_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    btn_lvl_d[i] = sync2_q[i];
                    rise[i]      = sync2_q[i];
                    fall[i]      = ~sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_ONE;
                end
            end
        end
    end

    // Hold state machine: times each debounced press and classifies it as short or long.
    always_comb begin
        press_d    = rise;
        release_d  = fall;
        short_d    = '0;
        long_d     = '0;
        long_lvl_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            state_d[i]    = state_q[i];
            hold_cnt_d[i] = hold_cnt_q[i];
            case (state_q[i])
                ST_IDLE: begin
                    if (rise[i]) begin
                        state_d[i]    = ST_HELD;
                        hold_cnt_d[i] = '0;
                    end
                end
                ST_HELD: begin
                    if (fall[i]) begin
                        state_d[i]    = ST_IDLE;
                        hold_cnt_d[i] = '0;
                        short_d[i]    = 1'b1;
                    end else if (hold_cnt_q[i] == HOLD_LAST) begin
                        state_d[i]    = ST_LONG;
                        hold_cnt_d[i] = HOLD_MAX;
                        long_d[i]     = 1'b1;
                    end else begin
                        hold_cnt_d[i] = hold_cnt_q[i] + HOLD_ONE;
                    end
                end
                ST_LONG: begin
                    if (fall[i]) begin
                        state_d[i]    = ST_IDLE;
                        hold_cnt_d[i] = '0;
                    end
                end
                default: begin
                    state_d[i]    = ST_IDLE;
                    hold_cnt_d[i] = '0;
                end
            endcase
            long_lvl_d[i] = (state_d[i] == ST_LONG);
        end
    end

    // State register for debounce counters, hold FSMs and the registered event outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_lvl_q  <= '0;
            press_q    <= '0;
            release_q  <= '0;
            short_q    <= '0;
            long_q     <= '0;
            long_lvl_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                db_cnt_q[i]   <= '0;
                hold_cnt_q[i] <= '0;
                state_q[i]    <= ST_IDLE;
            end
        end else begin
            btn_lvl_q  <= btn_lvl_d;
            press_q    <= press_d;
            release_q  <= release_d;
            short_q    <= short_d;
            long_q     <= long_d;
            long_lvl_q <= long_lvl_d;
            for (int i = 0; i < N_CH; i++) begin
                db_cnt_q[i]   <= db_cnt_d[i];
                hold_cnt_q[i] <= hold_cnt_d[i];
                state_q[i]    <= state_d[i];
            end
        end
    end

    assign btn_lvl       = btn_lvl_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign short_pulse   = short_q;
    assign long_pulse    = long_q;
    assign long_lvl      = long_lvl_q;

`ifdef BTN_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYC + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYC - 1);
    localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);

    logic [REP_W-1:0] rep_cnt_q [N_CH];
    logic [REP_W-1:0] rep_cnt_d [N_CH];
    logic [N_CH-1:0]  rep_q, rep_d;

    // Auto-repeat: while in LONG, fire every REPEAT_CYC cycles; the release cycle never repeats.
    always_comb begin
        rep_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            rep_cnt_d[i] = '0;
            if (state_q[i] == ST_LONG && !fall[i]) begin
                if (rep_cnt_q[i] == REP_LAST) begin
                    rep_d[i] = 1'b1;
                end else begin
                    rep_cnt_d[i] = rep_cnt_q[i] + REP_ONE;
                end
            end
        end
    end

    // Repeat counter and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                rep_cnt_q[i] <= '0;
            end
        end else begin
            rep_q <= rep_d;
            for (int i = 0; i < N_CH; i++) begin
                rep_cnt_q[i] <= rep_cnt_d[i];
            end
        end
    end

    assign rep_pulse = rep_q;
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = (REPEAT_CYC > 0);
    assign rep_pulse = '0;
`endif

endmodule
